// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

  // Loader FSM states; RUN is the reset state and the only one that lets the core run.
  typedef enum logic [2:0] {
    RUN    = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    FINISH = 3'd4,
    ERR    = 3'd5
  } loader_state_e;

  // Length header size and payload word size, in bytes.
  localparam int unsigned LEN_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;

  // Byte address of a word index (word aligned).
  function automatic logic [31:0] word_addr(input logic [15:0] idx);
    return {14'd0, idx, 2'd0};
  endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Little-endian byte-to-word packer: the first byte of a word lands in [7:0].
// The completed word is presented combinationally together with the 4th byte
// so the loader can register the memory write with no bubble.
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic [31:0] word,
  output logic        word_valid
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] shift_q, shift_d;

  assign word       = {in_byte, shift_q};
  assign word_valid = in_valid && (cnt_q == LAST_BYTE);

  // Next byte count and shift contents; clear wins over an incoming byte.
  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (clear) begin
      cnt_d   = 2'd0;
      shift_d = 24'd0;
    end else if (in_valid) begin
      cnt_d   = cnt_q + 2'd1;
      shift_d = {in_byte, shift_q[23:8]};
    end else begin
      cnt_d   = cnt_q;
      shift_d = shift_q;
    end
  end

  // Packer state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= 2'd0;
      shift_q <= 24'd0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed byte stream, writes it into the
// instruction memory and holds the core in reset until the image is complete.
module imem_boot_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS    = 64,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [31:0] imem_waddr,
  output logic [31:0] imem_wdata,
  output logic        core_reset,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  localparam logic [15:0] MAX_LEN    = 16'(DEPTH_WORDS);
  localparam logic [31:0] IDLE_LIMIT = 32'(TIMEOUT_CYCLES - 1);

  loader_state_e state_q, state_d;
  logic [31:0] idle_q, idle_d;
  logic [7:0]  len_lo_q, len_lo_d;
  logic [15:0] len_q, len_d;
  logic [15:0] word_idx_q, word_idx_d;
  logic [15:0] words_loaded_q, words_loaded_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        imem_we_q, imem_we_d;
  logic [31:0] imem_waddr_q, imem_waddr_d;
  logic [31:0] imem_wdata_q, imem_wdata_d;
  logic        byte_ready_q, byte_ready_d;
  logic        core_reset_q, core_reset_d;

  logic        xfer_s, pack_in_s, pack_clear_s, word_valid_s, timeout_s, last_word_s;
  logic [31:0] packed_word_s;
  logic [15:0] len_n_s;

  assign xfer_s      = byte_valid && byte_ready_q;
  assign pack_in_s   = xfer_s && (state_q == DATA);
  assign timeout_s   = (idle_q >= IDLE_LIMIT);
  assign len_n_s     = {byte_data, len_lo_q};
  assign last_word_s = ((word_idx_q + 16'd1) == len_q);

  imem_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (pack_clear_s),
    .in_valid   (pack_in_s),
    .in_byte    (byte_data),
    .word       (packed_word_s),
    .word_valid (word_valid_s)
  );

  // Next-state, idle timer, word bookkeeping and next values of every output register.
  always_comb begin
    state_d        = state_q;
    idle_d         = idle_q;
    len_lo_d       = len_lo_q;
    len_d          = len_q;
    word_idx_d     = word_idx_q;
    words_loaded_d = words_loaded_q;
    done_d         = done_q;
    error_d        = error_q;
    imem_we_d      = 1'b0;
    imem_waddr_d   = imem_waddr_q;
    imem_wdata_d   = imem_wdata_q;
    pack_clear_s   = 1'b0;

    case (state_q)
      RUN, ERR: begin
        if (start) begin
          state_d        = LEN_LO;
          idle_d         = 32'd0;
          word_idx_d     = 16'd0;
          words_loaded_d = 16'd0;
          done_d         = 1'b0;
          error_d        = 1'b0;
          pack_clear_s   = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      LEN_LO: begin
        if (xfer_s) begin
          len_lo_d = byte_data;
          idle_d   = 32'd0;
          state_d  = LEN_HI;
        end else if (timeout_s) begin
          state_d = ERR;
          error_d = 1'b1;
        end else begin
          idle_d = idle_q + 32'd1;
        end
      end
      LEN_HI: begin
        if (xfer_s) begin
          idle_d = 32'd0;
          len_d  = len_n_s;
          if ((len_n_s == 16'd0) || (len_n_s > MAX_LEN)) begin
            state_d = ERR;
            error_d = 1'b1;
          end else begin
            state_d = DATA;
          end
        end else if (timeout_s) begin
          state_d = ERR;
          error_d = 1'b1;
        end else begin
          idle_d = idle_q + 32'd1;
        end
      end
      DATA: begin
        if (xfer_s) begin
          idle_d = 32'd0;
          if (word_valid_s) begin
            imem_we_d      = 1'b1;
            imem_waddr_d   = word_addr(word_idx_q);
            imem_wdata_d   = packed_word_s;
            word_idx_d     = word_idx_q + 16'd1;
            words_loaded_d = words_loaded_q + 16'd1;
            if (last_word_s) begin
              state_d = FINISH;
            end else begin
              state_d = DATA;
            end
          end else begin
            state_d = DATA;
          end
        end else if (timeout_s) begin
          state_d = ERR;
          error_d = 1'b1;
        end else begin
          idle_d = idle_q + 32'd1;
        end
      end
      FINISH: begin
        state_d = RUN;
        done_d  = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    case (state_d)
      LEN_LO, LEN_HI, DATA: byte_ready_d = 1'b1;
      default:              byte_ready_d = 1'b0;
    endcase
    core_reset_d = (state_d != RUN);
  end

  // State and output registers; reset aborts any load and lets the core run.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= RUN;
      idle_q         <= 32'd0;
      len_lo_q       <= 8'd0;
      len_q          <= 16'd0;
      word_idx_q     <= 16'd0;
      words_loaded_q <= 16'd0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      imem_we_q      <= 1'b0;
      imem_waddr_q   <= 32'd0;
      imem_wdata_q   <= 32'd0;
      byte_ready_q   <= 1'b0;
      core_reset_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      idle_q         <= idle_d;
      len_lo_q       <= len_lo_d;
      len_q          <= len_d;
      word_idx_q     <= word_idx_d;
      words_loaded_q <= words_loaded_d;
      done_q         <= done_d;
      error_q        <= error_d;
      imem_we_q      <= imem_we_d;
      imem_waddr_q   <= imem_waddr_d;
      imem_wdata_q   <= imem_wdata_d;
      byte_ready_q   <= byte_ready_d;
      core_reset_q   <= core_reset_d;
    end
  end

  assign byte_ready   = byte_ready_q;
  assign imem_we      = imem_we_q;
  assign imem_waddr   = imem_waddr_q;
  assign imem_wdata   = imem_wdata_q;
  assign core_reset   = core_reset_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader with hand-computed expectations.
module tb_imem_boot_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        imem_we;
  logic [31:0] imem_waddr;
  logic [31:0] imem_wdata;
  logic        core_reset;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  imem_boot_loader #(
    .DEPTH_WORDS    (64),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .imem_we      (imem_we),
    .imem_waddr   (imem_waddr),
    .imem_wdata   (imem_wdata),
    .core_reset   (core_reset),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every memory write strobe, sampled mid-cycle.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_addr.push_back(imem_waddr);
      wr_data.push_back(imem_wdata);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Send bytes; after the call the view is one cycle after the last transfer edge.
  task automatic send_bytes(input logic [7:0] b[$], input int gap, output int cycles);
    logic seen;
    int   budget;
    cycles = 0;
    foreach (b[k]) begin
      byte_valid = 1'b1;
      byte_data  = b[k];
      budget     = 0;
      do begin
        seen = byte_ready;
        @(posedge clk);
        #1;
        cycles++;
        budget++;
      end while (!seen && budget < 200);
      if (!seen) begin
        check_eq("send_timeout", 32'd1, 32'd0);
        byte_valid = 1'b0;
        return;
      end
      if (gap > 0 && k != b.size() - 1) begin
        byte_valid = 1'b0;
        step(gap);
        cycles += gap;
      end
    end
    byte_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  logic [7:0] img[$];
  logic [7:0] part[$];
  int         cyc;

  initial begin
    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    img = '{8'h02, 8'h00, 8'h13, 8'h07, 8'h10, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};

    // Reset state
    step(2);
    reset = 1'b0;
    step(5);
    check_eq("rst_core_reset", {31'd0, core_reset}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_error", {31'd0, error}, 32'd0);
    check_eq("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
    check_eq("rst_words", {16'd0, words_loaded}, 32'd0);
    check_eq("rst_no_we", wr_addr.size(), 32'd0);

    // Good image, back-to-back
    clear_log();
    do_start();
    check_eq("start_core_reset", {31'd0, core_reset}, 32'd1);
    check_eq("start_byte_ready", {31'd0, byte_ready}, 32'd1);
    send_bytes(img, 0, cyc);
    check_eq("b2b_cycles", cyc, 32'd10);
    check_eq("last_we", {31'd0, imem_we}, 32'd1);
    check_eq("last_ready_low", {31'd0, byte_ready}, 32'd0);
    check_eq("last_core_reset_hi", {31'd0, core_reset}, 32'd1);
    check_eq("last_done_low", {31'd0, done}, 32'd0);
    step(1);
    check_eq("fin_core_reset", {31'd0, core_reset}, 32'd0);
    check_eq("fin_done", {31'd0, done}, 32'd1);
    check_eq("fin_error", {31'd0, error}, 32'd0);
    check_eq("fin_words", {16'd0, words_loaded}, 32'd2);
    check_eq("b2b_nwr", wr_addr.size(), 32'd2);
    if (wr_addr.size() == 2) begin
      check_eq("b2b_a0", wr_addr[0], 32'h0);
      check_eq("b2b_d0", wr_data[0], 32'h00100713);
      check_eq("b2b_a1", wr_addr[1], 32'h4);
      check_eq("b2b_d1", wr_data[1], 32'h00100593);
    end

    // Same image with byte_valid every other cycle
    clear_log();
    do_start();
    check_eq("gap_done_cleared", {31'd0, done}, 32'd0);
    check_eq("gap_words_cleared", {16'd0, words_loaded}, 32'd0);
    part = '{8'h02, 8'h00, 8'h13, 8'h07, 8'h10};
    send_bytes(part, 1, cyc);
    step(1);
    check_eq("gap_no_early_we", wr_addr.size(), 32'd0);
    part = '{8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    send_bytes(part, 1, cyc);
    step(2);
    check_eq("gap_done", {31'd0, done}, 32'd1);
    check_eq("gap_core_reset", {31'd0, core_reset}, 32'd0);
    check_eq("gap_words", {16'd0, words_loaded}, 32'd2);
    check_eq("gap_nwr", wr_addr.size(), 32'd2);
    if (wr_addr.size() == 2) begin
      check_eq("gap_a0", wr_addr[0], 32'h0);
      check_eq("gap_d0", wr_data[0], 32'h00100713);
      check_eq("gap_a1", wr_addr[1], 32'h4);
      check_eq("gap_d1", wr_data[1], 32'h00100593);
    end

    // Zero length
    clear_log();
    do_start();
    part = '{8'h00, 8'h00};
    send_bytes(part, 0, cyc);
    check_eq("len0_error", {31'd0, error}, 32'd1);
    check_eq("len0_ready", {31'd0, byte_ready}, 32'd0);
    step(3);
    check_eq("len0_core_reset", {31'd0, core_reset}, 32'd1);
    check_eq("len0_no_we", wr_addr.size(), 32'd0);

    // Length 65 exceeds depth
    do_start();
    check_eq("len65_err_cleared", {31'd0, error}, 32'd0);
    part = '{8'h41, 8'h00};
    send_bytes(part, 0, cyc);
    check_eq("len65_error", {31'd0, error}, 32'd1);
    check_eq("len65_ready", {31'd0, byte_ready}, 32'd0);
    step(3);
    check_eq("len65_core_reset", {31'd0, core_reset}, 32'd1);
    check_eq("len65_no_we", wr_addr.size(), 32'd0);

    // Timeout: stall after 2 data bytes
    do_start();
    part = '{8'h01, 8'h00, 8'hAA, 8'hBB};
    send_bytes(part, 0, cyc);
    step(15);
    check_eq("to_not_yet", {31'd0, error}, 32'd0);
    check_eq("to_ready_still", {31'd0, byte_ready}, 32'd1);
    step(1);
    check_eq("to_error", {31'd0, error}, 32'd1);
    check_eq("to_core_reset", {31'd0, core_reset}, 32'd1);
    check_eq("to_ready_low", {31'd0, byte_ready}, 32'd0);
    clear_log();
    do_start();
    send_bytes(img, 0, cyc);
    step(1);
    check_eq("rec_done", {31'd0, done}, 32'd1);
    check_eq("rec_error", {31'd0, error}, 32'd0);
    check_eq("rec_nwr", wr_addr.size(), 32'd2);

    // Reset mid-DATA after word 0 was written
    clear_log();
    do_start();
    part = '{8'h02, 8'h00, 8'h13, 8'h07, 8'h10, 8'h00, 8'h93};
    send_bytes(part, 0, cyc);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check_eq("mid_core_reset", {31'd0, core_reset}, 32'd0);
    check_eq("mid_ready", {31'd0, byte_ready}, 32'd0);
    check_eq("mid_words", {16'd0, words_loaded}, 32'd0);
    check_eq("mid_nwr", wr_addr.size(), 32'd1);

    // start during FINISH is ignored
    do_start();
    send_bytes(img, 0, cyc);
    start = 1'b1;
    step(1);
    start = 1'b0;
    check_eq("fin_start_core_reset", {31'd0, core_reset}, 32'd0);
    check_eq("fin_start_done", {31'd0, done}, 32'd1);
    step(1);
    check_eq("fin_start_stays_run", {31'd0, core_reset}, 32'd0);
    check_eq("fin_start_ready", {31'd0, byte_ready}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Loads a program image into the single-cycle core's instruction memory from a byte stream and holds the core in reset for the whole load. It sits between a byte source (UART receiver or test host) and the instruction memory write port. After a valid image is written it releases the core to fetch from address 0. On a malformed or stalled stream it latches an error and keeps the core in reset.

## Interface
- `DEPTH_WORDS`, default 64: instruction memory depth in 32-bit words; maximum image length.
- `TIMEOUT_CYCLES`, default 1_000_000: maximum idle cycles between accepted bytes while loading.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a load.
- `byte_valid`  in  1  source has a byte.
- `byte_data`  in  8  stream byte.
- `byte_ready`  out  1  loader accepts the byte this cycle.
- `imem_we`  out  1  one-cycle instruction memory write strobe.
- `imem_waddr`  out  32  byte address of the write, word aligned.
- `imem_wdata`  out  32  instruction word.
- `core_reset`  out  1  holds the core in reset, active high.
- `done`  out  1  sticky: last load completed.
- `error`  out  1  sticky: last load failed.
- `words_loaded`  out  16  words written in the current or last load.

## Operation
- Transfer occurs when `byte_valid && byte_ready`.
- Stream format:
  - 2-byte word count N, little-endian.
  - Then 4·N bytes, little-endian per word: the first byte goes to [7:0].
- FSM states: RUN, LEN_LO, LEN_HI, DATA, FINISH, ERR.
- Reset puts the FSM in RUN and forces all outputs to 0. `core_reset`=0, so the core runs the resident image.
- RUN or ERR, `start`=1 → LEN_LO.
  - On this transition, clear `done`, `error`, `words_loaded`, the byte counter and the word index.
- LEN_LO, on transfer → LEN_HI.
- LEN_HI, on transfer:
  - N==0 or N>DEPTH_WORDS → ERR.
  - Otherwise → DATA.
- DATA collects bytes 0..3 with a 2-bit counter.
  - On the 4th byte, a registered write is issued: `imem_waddr`=word_idx<<2, `imem_wdata`=assembled word.
  - word_idx and `words_loaded` increment.
  - On the N-th word → FINISH.
- FINISH → RUN unconditionally and sets `done`=1.
- `start` is ignored in LEN_LO, LEN_HI, DATA and FINISH.
- `byte_ready`=1 only in LEN_LO, LEN_HI and DATA.
- `core_reset`=1 in every state except RUN.
- Timeout: an idle counter clears on each transfer and on entry to LEN_LO.
  - In LEN_LO, LEN_HI or DATA, reaching TIMEOUT_CYCLES-1 → ERR.
- ERR sets `error`=1 and keeps `core_reset`=1 until `start` or `reset`.
- `reset` mid-load aborts at once and returns to RUN.
  - Partially written memory words are not restored.

## Timing
- All outputs are registered.
- `start` at cycle T: `core_reset`=1 and `byte_ready`=1 at T+1.
- 4th byte of a word accepted at cycle T: `imem_we`=1 for exactly one cycle at T+1.
  - A new byte may be accepted at T+1.
- Last byte accepted at T:
  - T+1: `imem_we`=1, state FINISH, `byte_ready`=0.
  - T+2: `core_reset`=0 and `done`=1.
- Length error detected on LEN_HI transfer at T: `error`=1 at T+1, `byte_ready`=0 from T+1.
- Sustained throughput is one byte per cycle, with no bubbles between words.

## Structure
- `imem_loader_pkg` holds:
  - the state enum `loader_state_e`;
  - `LEN_BYTES`=2;
  - `BYTES_PER_WORD`=4.
- Sub-module `imem_word_packer`:
  - shifts bytes into a 32-bit word;
  - pulses `word_valid` on the 4th byte;
  - clears on the FSM's `clear` input.
- The FSM, timeout counter and output registers live in the top module.

## Test plan
- Reset, no stimulus → `core_reset`=0, `done`=0, `error`=0, `imem_we` never asserted.
- `start`, stream 02 00 | 13 07 10 00 | 93 05 10 00 at one byte/cycle:
  - writes 0x00100713 @0x0 and 0x00100593 @0x4;
  - `words_loaded`=2;
  - `core_reset` falls 2 cycles after the last byte;
  - `done`=1.
- Same image with `byte_valid` toggled every other cycle → identical writes and final state; no write while fewer than 4 bytes are held.
- Length 00 00, and separately 41 00 (65 > DEPTH_WORDS) → `error`=1, `core_reset` stays 1, no `imem_we`.
- `TIMEOUT_CYCLES`=16, stall after 2 data bytes → ERR after 16 idle cycles. A following `start` and a good image → `done`=1, `error`=0.
- `reset` asserted mid-DATA after word 0 is written → next cycle: RUN, `core_reset`=0, `byte_ready`=0. `start` during FINISH is ignored.
